// File: rtl/pilot_phase_corr_if.sv
// pilot_phase_corr_if: sample/pilot/output bundle for the common-phase-error corrector
// Signals: in_valid/in_ready/in_r/in_i     data subcarriers from the FFT/pilot-extract stage
//          pilot_valid/pilot_r/pilot_i     conjugated pilot average strobe and value
//          out_valid/out_last/out_r/out_i  corrected samples to the demapper (no backpressure)
// Modports: master = surrounding receiver chain, slave = corrector
interface pilot_phase_corr_if #(parameter int Q = 16);
   logic in_valid;
   logic in_ready;
   logic signed [Q-1:0] in_r;
   logic signed [Q-1:0] in_i;
   logic pilot_valid;
   logic signed [Q-1:0] pilot_r;
   logic signed [Q-1:0] pilot_i;
   logic out_valid;
   logic out_last;
   logic signed [Q-1:0] out_r;
   logic signed [Q-1:0] out_i;
   modport master(output in_valid, in_r, in_i, pilot_valid, pilot_r, pilot_i,
                  input in_ready, out_valid, out_last, out_r, out_i);
   modport slave(input in_valid, in_r, in_i, pilot_valid, pilot_r, pilot_i,
                 output in_ready, out_valid, out_last, out_r, out_i);
endinterface

// File: rtl/pilot_phase_corr.sv
// pilot_phase_corr: buffers one OFDM symbol, multiplies each data subcarrier by that symbol's conjugated pilot
// Ports: clk    rising-edge clock
//        rst_n  asynchronous reset, active-high
//        bus    pilot_phase_corr_if slave: data in (valid/ready), pilot strobe, corrected data out
module pilot_phase_corr #(
   parameter int Q      = 16,
   parameter int Q_DEC  = 9,
   parameter int N_DATA = 48
) (
   input logic clk,
   input logic rst_n,
   pilot_phase_corr_if.slave bus
);
   localparam int AW = $clog2(N_DATA);
   localparam logic [AW-1:0] LAST = AW'(N_DATA - 1);
   localparam logic signed [2*Q:0] MAXV = {{(Q+2){1'b0}}, {(Q-1){1'b1}}};
   localparam logic signed [2*Q:0] MINV = {{(Q+2){1'b1}}, {(Q-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, FILL, WAIT, DRAIN} state_t;
   state_t state, state_n;
   logic [AW-1:0] count, count_n;
   logic rdy, acc, go, rd;
   logic pend;
   logic signed [Q-1:0] stg_r, stg_i, act_r, act_i;
   logic [2*Q-1:0] mem [N_DATA];
   logic [2*Q-1:0] rd_data;
   logic rd_v, rd_last;
   logic signed [Q-1:0] d_r, d_i;
   logic signed [2*Q:0] full_r, full_i;
   function automatic logic signed [2*Q:0] ext(input logic signed [Q-1:0] v);
      return {{(Q+1){v[Q-1]}}, v};
   endfunction
   // floor shift by Q_DEC, then clamp to the Q-bit signed range
   function automatic logic signed [Q-1:0] sat(input logic signed [2*Q:0] v);
      logic signed [2*Q:0] s;
      s = v >>> Q_DEC;
      return s > MAXV ? MAXV[Q-1:0] : s < MINV ? MINV[Q-1:0] : s[Q-1:0];
   endfunction
   always_comb begin
      state_n = state;
      count_n = count;
      rdy = (state == IDLE) || (state == FILL);
      acc = bus.in_valid && rdy;
      go = (state == WAIT) && (pend || bus.pilot_valid);
      rd = state == DRAIN;
      case (state)
         IDLE: if (acc) begin
            state_n = FILL;
            count_n = AW'(1);
         end
         FILL: if (acc) begin
            state_n = count == LAST ? WAIT : FILL;
            count_n = count == LAST ? '0 : count + 1'b1;
         end
         WAIT: if (go) state_n = DRAIN;
         DRAIN: begin
            state_n = count == LAST ? IDLE : DRAIN;
            count_n = count == LAST ? '0 : count + 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end
   assign bus.in_ready = rdy;
   // count doubles as write address in FILL and read address in DRAIN
   always_ff @(posedge clk) begin
      if (acc) mem[count] <= {bus.in_r, bus.in_i};
      if (rd) rd_data <= mem[count];
   end
   always_comb begin
      d_r = rd_data[2*Q-1:Q];
      d_i = rd_data[Q-1:0];
      full_r = ext(d_r) * ext(act_r) - ext(d_i) * ext(act_i);
      full_i = ext(d_r) * ext(act_i) + ext(d_i) * ext(act_r);
   end
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state <= IDLE;
         count <= '0;
         pend <= 1'b0;
         stg_r <= '0;
         stg_i <= '0;
         act_r <= '0;
         act_i <= '0;
         rd_v <= 1'b0;
         rd_last <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_last <= 1'b0;
         bus.out_r <= '0;
         bus.out_i <= '0;
      end else begin
         state <= state_n;
         count <= count_n;
         // a pilot consumed on the WAIT->DRAIN edge never leaves pend behind
         pend <= go ? 1'b0 : (bus.pilot_valid ? 1'b1 : pend);
         if (bus.pilot_valid) begin
            stg_r <= bus.pilot_r;
            stg_i <= bus.pilot_i;
         end
         if (go) begin
            act_r <= bus.pilot_valid ? bus.pilot_r : stg_r;
            act_i <= bus.pilot_valid ? bus.pilot_i : stg_i;
         end
         rd_v <= rd;
         rd_last <= rd && (count == LAST);
         bus.out_valid <= rd_v;
         bus.out_last <= rd_last;
         if (rd_v) begin
            bus.out_r <= sat(full_r);
            bus.out_i <= sat(full_i);
         end
      end
   end
endmodule

// File: tb/tb_pilot_phase_corr.sv
// tb_pilot_phase_corr: directed self-checking bench for pilot_phase_corr
module tb_pilot_phase_corr;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   pilot_phase_corr_if #(.Q(16)) bus();
   pilot_phase_corr #(.Q(16), .Q_DEC(9), .N_DATA(48)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int n_assert = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_acc = 0;
   logic signed [15:0] sym_r [48];
   logic signed [15:0] sym_i [48];
   logic signed [15:0] exp_r [48];
   logic signed [15:0] exp_i [48];
   logic signed [15:0] obs_r [$];
   logic signed [15:0] obs_i [$];
   logic obs_l [$];
   int obs_c [$];
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.out_valid === 1'b1) begin
      obs_r.push_back(bus.out_r);
      obs_i.push_back(bus.out_i);
      obs_l.push_back(bus.out_last);
      obs_c.push_back(cyc);
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end
   task automatic clear_obs();
      obs_r.delete();
      obs_i.delete();
      obs_l.delete();
      obs_c.delete();
   endtask
   // streams sym_r/sym_i whenever in_ready is high, pulsing pilots with samples pa and pb
   task automatic feed(input int pa, input logic signed [15:0] par, input logic signed [15:0] pai,
                       input int pb, input logic signed [15:0] pbr, input logic signed [15:0] pbi);
      int k = 0;
      int g = 0;
      while (k < 48 && g < 300) begin
         @(negedge clk);
         g++;
         bus.pilot_valid = 1'b0;
         if (bus.in_ready === 1'b1) begin
            bus.in_valid = 1'b1;
            bus.in_r = sym_r[k];
            bus.in_i = sym_i[k];
            if (k == pa) begin bus.pilot_valid = 1'b1; bus.pilot_r = par; bus.pilot_i = pai; end
            if (k == pb) begin bus.pilot_valid = 1'b1; bus.pilot_r = pbr; bus.pilot_i = pbi; end
            k++;
         end else bus.in_valid = 1'b0;
      end
      n_assert++;
      if (k != 48) begin
         n_fail++;
         $display("FAIL feed_timeout: accepted %0d samples, required 48", k);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.pilot_valid = 1'b0;
      last_acc = cyc;
   endtask
   task automatic pulse(input logic signed [15:0] pr, input logic signed [15:0] pi);
      bus.pilot_valid = 1'b1;
      bus.pilot_r = pr;
      bus.pilot_i = pi;
      @(negedge clk);
      bus.pilot_valid = 1'b0;
   endtask
   task automatic gather(input int n);
      int g = 0;
      while (obs_r.size() < n && g < 400) begin
         @(negedge clk);
         g++;
      end
      n_assert++;
      if (obs_r.size() < n) begin
         n_fail++;
         $display("FAIL gather_timeout: got %0d outputs, required %0d", obs_r.size(), n);
      end
   endtask
   task automatic test_reset();
      n_assert++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
          bus.out_r !== 16'sd0 || bus.out_i !== 16'sd0) begin
         n_fail++;
         $display("FAIL reset_state: rdy=%b ov=%b ol=%b r=%0d i=%0d, required 1 0 0 0 0",
                  bus.in_ready, bus.out_valid, bus.out_last, bus.out_r, bus.out_i);
      end
   endtask
   task automatic test_identity();
      clear_obs();
      for (int k = 0; k < 48; k++) begin
         sym_r[k] = 16'(k); sym_i[k] = 16'(-k); exp_r[k] = 16'(k); exp_i[k] = 16'(-k);
      end
      feed(10, 16'sd512, 16'sd0, -1, 16'sd0, 16'sd0);
      gather(48);
      n_assert++;
      if (obs_c[0] !== last_acc + 3) begin
         n_fail++;
         $display("FAIL identity_latency: first out at edge %0d, required %0d", obs_c[0], last_acc + 3);
      end
      for (int j = 0; j < 48; j++) begin
         n_assert++;
         if (obs_r[j] !== exp_r[j] || obs_i[j] !== exp_i[j] || obs_l[j] !== (j == 47) || obs_c[j] !== obs_c[0] + j) begin
            n_fail++;
            $display("FAIL identity[%0d]: got (%0d,%0d,last=%b,edge=%0d) required (%0d,%0d,last=%b,edge=%0d)",
                     j, obs_r[j], obs_i[j], obs_l[j], obs_c[j], exp_r[j], exp_i[j], j == 47, obs_c[0] + j);
         end
      end
   endtask
   task automatic test_rotation();
      clear_obs();
      for (int k = 0; k < 48; k++) begin sym_r[k] = 16'sd100; sym_i[k] = 16'sd50; end
      feed(-1, 16'sd0, 16'sd0, -1, 16'sd0, 16'sd0);
      for (int c = 0; c < 10; c++) begin
         n_assert++;
         if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rotation_wait_ready[%0d]: got %b required 0", c, bus.in_ready); end
         @(negedge clk);
      end
      n_assert++;
      if (obs_r.size() != 0) begin n_fail++; $display("FAIL rotation_early_out: got %0d outputs required 0", obs_r.size()); end
      pulse(16'sd0, 16'sd512);
      for (int c = 0; c < 48; c++) begin
         n_assert++;
         if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rotation_drain_ready[%0d]: got %b required 0", c, bus.in_ready); end
         @(negedge clk);
      end
      n_assert++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rotation_idle_ready: got %b required 1", bus.in_ready); end
      gather(48);
      for (int j = 0; j < 48; j++) begin
         n_assert++;
         if (obs_r[j] !== -16'sd50 || obs_i[j] !== 16'sd100 || obs_l[j] !== (j == 47)) begin
            n_fail++;
            $display("FAIL rotation[%0d]: got (%0d,%0d,last=%b) required (-50,100,last=%b)", j, obs_r[j], obs_i[j], obs_l[j], j == 47);
         end
      end
   endtask
   task automatic test_saturation();
      clear_obs();
      for (int k = 0; k < 48; k++) begin sym_r[k] = 16'sd32767; sym_i[k] = -16'sd32768; end
      feed(5, 16'sd1024, 16'sd0, -1, 16'sd0, 16'sd0);
      gather(48);
      for (int j = 0; j < 48; j += 47) begin
         n_assert++;
         if (obs_r[j] !== 16'sd32767 || obs_i[j] !== -16'sd32768) begin
            n_fail++;
            $display("FAIL saturate[%0d]: got (%0d,%0d) required (32767,-32768)", j, obs_r[j], obs_i[j]);
         end
      end
      clear_obs();
      for (int k = 0; k < 48; k++) begin sym_r[k] = -16'sd3; sym_i[k] = 16'sd3; end
      feed(5, 16'sd256, 16'sd0, -1, 16'sd0, 16'sd0);
      gather(48);
      for (int j = 0; j < 48; j += 47) begin
         n_assert++;
         if (obs_r[j] !== -16'sd2 || obs_i[j] !== 16'sd1) begin
            n_fail++;
            $display("FAIL floor_shift[%0d]: got (%0d,%0d) required (-2,1)", j, obs_r[j], obs_i[j]);
         end
      end
   endtask
   task automatic test_pilot_same_cycle();
      clear_obs();
      for (int k = 0; k < 48; k++) begin sym_r[k] = 16'(k + 100); sym_i[k] = 16'(2 * k); end
      feed(47, 16'sd512, 16'sd0, -1, 16'sd0, 16'sd0);
      gather(48);
      n_assert++;
      if (obs_c[0] !== last_acc + 3) begin
         n_fail++;
         $display("FAIL same_cycle_latency: first out at edge %0d, required %0d", obs_c[0], last_acc + 3);
      end
      for (int j = 0; j < 48; j += 23) begin
         n_assert++;
         if (obs_r[j] !== 16'(j + 100) || obs_i[j] !== 16'(2 * j)) begin
            n_fail++;
            $display("FAIL same_cycle[%0d]: got (%0d,%0d) required (%0d,%0d)", j, obs_r[j], obs_i[j], j + 100, 2 * j);
         end
      end
   endtask
   task automatic test_two_pilots();
      clear_obs();
      for (int k = 0; k < 48; k++) begin sym_r[k] = 16'(k); sym_i[k] = 16'(k); end
      feed(3, 16'sd0, 16'sd512, 20, -16'sd512, 16'sd0);
      gather(48);
      for (int j = 0; j < 48; j += 9) begin
         n_assert++;
         if (obs_r[j] !== 16'(-j) || obs_i[j] !== 16'(-j)) begin
            n_fail++;
            $display("FAIL latest_pilot[%0d]: got (%0d,%0d) required (%0d,%0d)", j, obs_r[j], obs_i[j], -j, -j);
         end
      end
   endtask
   task automatic test_back_to_back();
      int acc_a;
      clear_obs();
      for (int k = 0; k < 48; k++) begin sym_r[k] = 16'(k); sym_i[k] = 16'(-k); end
      feed(0, 16'sd512, 16'sd0, -1, 16'sd0, 16'sd0);
      acc_a = last_acc;
      @(negedge clk);
      pulse(16'sd0, 16'sd512);
      for (int k = 0; k < 48; k++) begin sym_r[k] = 16'(k); sym_i[k] = 16'(2 * k); end
      feed(-1, 16'sd0, 16'sd0, -1, 16'sd0, 16'sd0);
      n_assert++;
      if (last_acc - acc_a !== 97) begin
         n_fail++;
         $display("FAIL b2b_period: got %0d cycles required 97", last_acc - acc_a);
      end
      gather(96);
      for (int j = 0; j < 96; j++) begin
         int k = j % 48;
         logic signed [15:0] er, ei;
         er = j < 48 ? 16'(k) : 16'(-2 * k);
         ei = j < 48 ? 16'(-k) : 16'(k);
         n_assert++;
         if (obs_r[j] !== er || obs_i[j] !== ei || obs_l[j] !== (k == 47)) begin
            n_fail++;
            $display("FAIL b2b[%0d]: got (%0d,%0d,last=%b) required (%0d,%0d,last=%b)", j, obs_r[j], obs_i[j], obs_l[j], er, ei, k == 47);
         end
      end
      n_assert++;
      if (obs_c[48] !== acc_a + 100) begin
         n_fail++;
         $display("FAIL b2b_second_start: got edge %0d required %0d", obs_c[48], acc_a + 100);
      end
   endtask
   task automatic test_reset_mid_drain();
      int g = 0;
      int n_seen;
      clear_obs();
      for (int k = 0; k < 48; k++) begin sym_r[k] = 16'(k + 1); sym_i[k] = 16'(-k - 1); end
      feed(0, 16'sd512, 16'sd0, -1, 16'sd0, 16'sd0);
      @(negedge clk);
      pulse(16'sd512, 16'sd0);
      while (obs_r.size() < 20 && g < 100) begin @(negedge clk); g++; end
      rst_n = 1'b1;
      #1;
      n_assert++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_drain: ov=%b rdy=%b required 0 1 (outputs seen %0d)", bus.out_valid, bus.in_ready, obs_r.size());
      end
      n_seen = obs_r.size();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_assert++;
      if (obs_r.size() != n_seen) begin
         n_fail++;
         $display("FAIL reset_flush: got %0d outputs required %0d", obs_r.size(), n_seen);
      end
      clear_obs();
      for (int k = 0; k < 48; k++) begin sym_r[k] = 16'(k); sym_i[k] = 16'sd3; end
      feed(-1, 16'sd0, 16'sd0, -1, 16'sd0, 16'sd0);
      repeat (5) @(negedge clk);
      n_assert++;
      if (obs_r.size() != 0 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL stale_pend: got %0d outputs rdy=%b required 0 outputs rdy=0", obs_r.size(), bus.in_ready);
      end
      pulse(16'sd0, 16'sd512);
      gather(48);
      for (int j = 0; j < 48; j += 7) begin
         n_assert++;
         if (obs_r[j] !== -16'sd3 || obs_i[j] !== 16'(j)) begin
            n_fail++;
            $display("FAIL after_reset[%0d]: got (%0d,%0d) required (-3,%0d)", j, obs_r[j], obs_i[j], j);
         end
      end
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.in_r = '0;
      bus.in_i = '0;
      bus.pilot_valid = 1'b0;
      bus.pilot_r = '0;
      bus.pilot_i = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      test_reset();
      test_identity();
      test_rotation();
      test_saturation();
      test_pilot_same_cycle();
      test_two_pilots();
      test_back_to_back();
      test_reset_mid_drain();
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
